// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path types and constants: reset PC, NOP encoding and the queued {pc, instr} pair.
package fetch_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] INSTR_NOP      = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch->decode handshake bundle; master is the fetch/decode side, slave is the queue.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count, empty, full
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count, empty, full
    );

endinterface

// File: rtl/fetch_queue.sv
// In-order {pc, instr} buffer between fetch and decode with single-cycle flush on redirect.
// Optional zero-latency empty bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    fetch_queue_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    fetch_entry_t     in_entry;
    fetch_entry_t     head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             empty_q;
    logic             full_q;
    logic             push;
    logic             pop;
    logic             bypass_c;
    logic             bypass_take;

    assign in_entry = '{pc: bus.in_pc, instr: bus.in_instr};
    assign head     = mem[rd_ptr];

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_c = empty_q & bus.in_valid & ~bus.flush;
`else
    assign bypass_c = 1'b0;
`endif

    // A bypassed pair that decode takes immediately is never written.
    assign bypass_take = bypass_c & bus.out_ready;
    assign push        = bus.in_valid & ~full_q & ~bus.flush & ~bypass_take;
    assign pop         = ~empty_q & bus.out_ready & ~bus.flush;

    always_comb begin
        count_d = count_q;
        if (bus.flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (bus.flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    always_comb begin
        bus.out_valid = ~empty_q | bypass_c;
        bus.out_pc    = '0;
        bus.out_instr = INSTR_NOP;
        if (!empty_q) begin
            bus.out_pc    = head.pc;
            bus.out_instr = head.instr;
        end else if (bypass_c) begin
            bus.out_pc    = in_entry.pc;
            bus.out_instr = in_entry.instr;
        end
    end

    assign bus.in_ready = ~full_q;
    assign bus.count    = count_q;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;

endmodule
